// File: rtl/branch_predict_ctrl.sv
// Branch prediction sequencer: 2-bit counters gate BTB hits in IF, EX resolution trains
// the counters, drives BTB writes and runs the redirect/flush sequence on mispredicts.
module branch_predict_ctrl #(
   parameter int WIDTH_DATA_LENGTH = 32,
   parameter int WIDTH_ENTRY_LENTH = 3,
   parameter int FLUSH_CYCLES      = 2,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [WIDTH_DATA_LENGTH-1:0]      PC,
   input  logic                              Hit,
   input  logic [WIDTH_DATA_LENGTH-1:0]      Target_Add,
   input  logic                              Stall_Detected,
   input  logic                              Ex_Valid,
   input  logic                              Ex_Is_Branch,
   input  logic                              Ex_Taken,
   input  logic [WIDTH_DATA_LENGTH-1:0]      PC_Ex,
   input  logic [WIDTH_DATA_LENGTH-1:0]      PC_ALU,
   input  logic                              Ex_Pred_Taken,
   input  logic [WIDTH_DATA_LENGTH-1:0]      Ex_Pred_Target,
   output logic                              Pred_Taken,
   output logic [WIDTH_DATA_LENGTH-1:0]      Pred_Target,
   output logic [WIDTH_DATA_LENGTH-1:0]      Next_PC,
   output logic                              Flush,
   output logic                              Btb_Wr,
   output logic [WIDTH_DATA_LENGTH-1:0]      Btb_Wr_PC,
   output logic [WIDTH_DATA_LENGTH-1:0]      Btb_Wr_Target,
   output logic [CNT_WIDTH-1:0]              Mispredict_Cnt,
   output logic [1:0]                        dbg_state,
   output logic [2*(1<<WIDTH_ENTRY_LENTH)-1:0] dbg_ctr
);

   localparam int DEPTH      = 1 << WIDTH_ENTRY_LENTH;
   localparam int DW         = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int DRAIN_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   state_t                         state;
   logic [1:0]                     ctr [DEPTH];
   logic [DW-1:0]                  drain_cnt;
   logic [WIDTH_DATA_LENGTH-1:0]   redirect_pc;

   logic [WIDTH_ENTRY_LENTH-1:0]   idx_if;
   logic [WIDTH_ENTRY_LENTH-1:0]   idx_ex;
   logic                           res;
   logic                           tgt_mismatch;
   logic                           mis;
   logic                           btb_req;

   assign idx_if = PC[WIDTH_ENTRY_LENTH+1:2];
   assign idx_ex = PC_Ex[WIDTH_ENTRY_LENTH+1:2];

   // Prediction reads the counter before any same-cycle EX update lands.
   always_comb begin
      Pred_Taken  = Hit & ctr[idx_if][1];
      Pred_Target = Target_Add;
      if (state == ST_REDIRECT)
         Next_PC = redirect_pc;
      else if (Pred_Taken)
         Next_PC = Target_Add;
      else
         Next_PC = PC + WIDTH_DATA_LENGTH'(4);
   end

   always_comb begin
      res          = Ex_Valid & Ex_Is_Branch & ~Stall_Detected & (state == ST_RUN);
      tgt_mismatch = (PC_ALU != Ex_Pred_Target);
      mis          = res & ((Ex_Taken != Ex_Pred_Taken) | (Ex_Taken & Ex_Pred_Taken & tgt_mismatch));
      btb_req      = res & Ex_Taken & (~Ex_Pred_Taken | tgt_mismatch);
   end

   always_comb begin
      dbg_state = state;
      dbg_ctr   = '0;
      for (int i = 0; i < DEPTH; i++)
         dbg_ctr[2*i +: 2] = ctr[i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_RUN;
         drain_cnt      <= '0;
         redirect_pc    <= '0;
         Flush          <= 1'b0;
         Btb_Wr         <= 1'b0;
         Btb_Wr_PC      <= '0;
         Btb_Wr_Target  <= '0;
         Mispredict_Cnt <= '0;
         for (int i = 0; i < DEPTH; i++)
            ctr[i] <= 2'b01;
      end else begin
         // The write pulse is a single cycle even if the pipeline stalls behind it.
         Btb_Wr <= btb_req;
         if (btb_req) begin
            Btb_Wr_PC     <= PC_Ex;
            Btb_Wr_Target <= PC_ALU;
         end

         if (!Stall_Detected) begin
            if (res) begin
               if (Ex_Taken) begin
                  if (ctr[idx_ex] != 2'b11)
                     ctr[idx_ex] <= ctr[idx_ex] + 2'd1;
               end else begin
                  if (ctr[idx_ex] != 2'b00)
                     ctr[idx_ex] <= ctr[idx_ex] - 2'd1;
               end
            end

            if (mis && (Mispredict_Cnt != {CNT_WIDTH{1'b1}}))
               Mispredict_Cnt <= Mispredict_Cnt + CNT_WIDTH'(1);

            case (state)
               ST_RUN: begin
                  if (mis) begin
                     state       <= ST_REDIRECT;
                     Flush       <= 1'b1;
                     redirect_pc <= Ex_Taken ? PC_ALU : PC_Ex + WIDTH_DATA_LENGTH'(4);
                  end
               end
               ST_REDIRECT: begin
                  if (FLUSH_CYCLES > 1) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DW'(DRAIN_LOAD);
                  end else begin
                     state <= ST_RUN;
                     Flush <= 1'b0;
                  end
               end
               ST_DRAIN: begin
                  if (drain_cnt == '0) begin
                     state <= ST_RUN;
                     Flush <= 1'b0;
                  end else begin
                     drain_cnt <= drain_cnt - DW'(1);
                  end
               end
               default: begin
                  state <= ST_RUN;
                  Flush <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: inputs change just after the falling edge and
// outputs are compared 1ns later, well clear of the rising edge.
module tb_branch_predict_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PC;
   logic        Hit;
   logic [31:0] Target_Add;
   logic        Stall_Detected;
   logic        Ex_Valid;
   logic        Ex_Is_Branch;
   logic        Ex_Taken;
   logic [31:0] PC_Ex;
   logic [31:0] PC_ALU;
   logic        Ex_Pred_Taken;
   logic [31:0] Ex_Pred_Target;
   logic        Pred_Taken;
   logic [31:0] Pred_Target;
   logic [31:0] Next_PC;
   logic        Flush;
   logic        Btb_Wr;
   logic [31:0] Btb_Wr_PC;
   logic [31:0] Btb_Wr_Target;
   logic [15:0] Mispredict_Cnt;
   logic [1:0]  dbg_state;
   logic [15:0] dbg_ctr;

   int n_tests = 0;
   int n_fail  = 0;
   int flush_cycles_seen;

   branch_predict_ctrl dut (
      .clk(clk), .rst_n(rst_n), .PC(PC), .Hit(Hit), .Target_Add(Target_Add),
      .Stall_Detected(Stall_Detected), .Ex_Valid(Ex_Valid), .Ex_Is_Branch(Ex_Is_Branch),
      .Ex_Taken(Ex_Taken), .PC_Ex(PC_Ex), .PC_ALU(PC_ALU), .Ex_Pred_Taken(Ex_Pred_Taken),
      .Ex_Pred_Target(Ex_Pred_Target), .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
      .Next_PC(Next_PC), .Flush(Flush), .Btb_Wr(Btb_Wr), .Btb_Wr_PC(Btb_Wr_PC),
      .Btb_Wr_Target(Btb_Wr_Target), .Mispredict_Cnt(Mispredict_Cnt),
      .dbg_state(dbg_state), .dbg_ctr(dbg_ctr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic ex_drive(input logic [31:0] pc_ex, input logic [31:0] alu, input logic taken,
                           input logic ptaken, input logic [31:0] ptarget);
      Ex_Valid = 1'b1; Ex_Is_Branch = 1'b1; Ex_Taken = taken;
      PC_Ex = pc_ex; PC_ALU = alu; Ex_Pred_Taken = ptaken; Ex_Pred_Target = ptarget;
   endtask

   task automatic ex_idle();
      Ex_Valid = 1'b0; Ex_Is_Branch = 1'b0; Ex_Taken = 1'b0;
      PC_Ex = '0; PC_ALU = '0; Ex_Pred_Taken = 1'b0; Ex_Pred_Target = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Stall_Detected = 1'b0; Hit = 1'b0;
      PC = 32'h1234_0000; Target_Add = 32'h0; ex_idle();
      step(); step(); #1;
      n_tests++; if (Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got=%0b exp=0", Pred_Taken); end
      n_tests++; if (Next_PC !== 32'h1234_0004) begin n_fail++; $display("FAIL reset_next_pc got=%h exp=12340004", Next_PC); end
      n_tests++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%0b exp=0", Flush); end
      n_tests++; if (Btb_Wr !== 1'b0) begin n_fail++; $display("FAIL reset_btb_wr got=%0b exp=0", Btb_Wr); end
      n_tests++; if (Mispredict_Cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", Mispredict_Cnt); end
      n_tests++; if (dbg_ctr !== 16'h5555) begin n_fail++; $display("FAIL reset_ctr got=%h exp=5555", dbg_ctr); end
      n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      PC = 32'hFFFF_FFFC; #1;
      n_tests++; if (Next_PC !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got=%h exp=00000000", Next_PC); end
   endtask

   task automatic test_mispredict_taken();
      step();
      rst_n = 1'b1; PC = 32'h1234_0010; Hit = 1'b0;
      ex_drive(32'h1234_0000, 32'hFFFF_AAAA, 1'b1, 1'b0, 32'h0);
      step(); ex_idle(); #1;
      n_tests++; if (Btb_Wr !== 1'b1) begin n_fail++; $display("FAIL mis_btb_wr got=%0b exp=1", Btb_Wr); end
      n_tests++; if (Btb_Wr_PC !== 32'h1234_0000) begin n_fail++; $display("FAIL mis_btb_pc got=%h exp=12340000", Btb_Wr_PC); end
      n_tests++; if (Btb_Wr_Target !== 32'hFFFF_AAAA) begin n_fail++; $display("FAIL mis_btb_tgt got=%h exp=ffffaaaa", Btb_Wr_Target); end
      n_tests++; if (Next_PC !== 32'hFFFF_AAAA) begin n_fail++; $display("FAIL mis_next_pc got=%h exp=ffffaaaa", Next_PC); end
      n_tests++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush1 got=%0b exp=1", Flush); end
      n_tests++; if (Mispredict_Cnt !== 16'd1) begin n_fail++; $display("FAIL mis_cnt got=%0d exp=1", Mispredict_Cnt); end
      n_tests++; if (dbg_ctr !== 16'h5556) begin n_fail++; $display("FAIL mis_ctr got=%h exp=5556", dbg_ctr); end
      step(); #1;
      n_tests++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush2 got=%0b exp=1", Flush); end
      n_tests++; if (Btb_Wr !== 1'b0) begin n_fail++; $display("FAIL mis_btb_clear got=%0b exp=0", Btb_Wr); end
      n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL mis_drain_state got=%0d exp=2", dbg_state); end
      n_tests++; if (Next_PC !== 32'h1234_0014) begin n_fail++; $display("FAIL mis_drain_next_pc got=%h exp=12340014", Next_PC); end
      step(); #1;
      n_tests++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL mis_flush_end got=%0b exp=0", Flush); end
      n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL mis_run_state got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_saturate();
      PC = 32'h1234_0000; Hit = 1'b1; Target_Add = 32'hFFFF_AAAA;
      for (int i = 0; i < 3; i++) begin
         ex_drive(32'h1234_0000, 32'hFFFF_AAAA, 1'b1, 1'b1, 32'hFFFF_AAAA);
         step();
      end
      ex_idle(); #1;
      n_tests++; if (dbg_ctr !== 16'h5557) begin n_fail++; $display("FAIL sat_ctr got=%h exp=5557", dbg_ctr); end
      n_tests++; if (Pred_Taken !== 1'b1) begin n_fail++; $display("FAIL sat_pred got=%0b exp=1", Pred_Taken); end
      n_tests++; if (Next_PC !== 32'hFFFF_AAAA) begin n_fail++; $display("FAIL sat_next_pc got=%h exp=ffffaaaa", Next_PC); end
      n_tests++; if (Pred_Target !== 32'hFFFF_AAAA) begin n_fail++; $display("FAIL sat_pred_tgt got=%h exp=ffffaaaa", Pred_Target); end
      n_tests++; if ({Flush, Btb_Wr} !== 2'b00) begin n_fail++; $display("FAIL sat_quiet got=%b exp=00", {Flush, Btb_Wr}); end
      n_tests++; if (Mispredict_Cnt !== 16'd1) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=1", Mispredict_Cnt); end
      ex_drive(32'h1234_0000, 32'h0000_0099, 1'b0, 1'b1, 32'hFFFF_AAAA);
      step(); ex_idle(); #1;
      n_tests++; if (dbg_ctr !== 16'h5556) begin n_fail++; $display("FAIL nt_ctr got=%h exp=5556", dbg_ctr); end
      n_tests++; if (Next_PC !== 32'h1234_0004) begin n_fail++; $display("FAIL nt_redirect got=%h exp=12340004", Next_PC); end
      n_tests++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL nt_flush got=%0b exp=1", Flush); end
      n_tests++; if (Btb_Wr !== 1'b0) begin n_fail++; $display("FAIL nt_no_btb got=%0b exp=0", Btb_Wr); end
      n_tests++; if (Mispredict_Cnt !== 16'd2) begin n_fail++; $display("FAIL nt_cnt got=%0d exp=2", Mispredict_Cnt); end
      step(); step();
      ex_drive(32'h1234_0000, 32'h0, 1'b0, 1'b0, 32'h0); #1;
      n_tests++; if (Pred_Taken !== 1'b1) begin n_fail++; $display("FAIL same_idx_pre got=%0b exp=1", Pred_Taken); end
      step(); ex_idle(); #1;
      n_tests++; if (Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL same_idx_post got=%0b exp=0", Pred_Taken); end
      n_tests++; if (Next_PC !== 32'h1234_0004) begin n_fail++; $display("FAIL same_idx_next_pc got=%h exp=12340004", Next_PC); end
      n_tests++; if ({Flush, Mispredict_Cnt} !== {1'b0, 16'd2}) begin n_fail++; $display("FAIL same_idx_nomis got=%0b/%0d exp=0/2", Flush, Mispredict_Cnt); end
   endtask

   task automatic test_stall_redirect();
      Hit = 1'b0; PC = 32'h1234_0020;
      flush_cycles_seen = 0;
      ex_drive(32'h1234_0008, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
      step(); ex_idle(); Stall_Detected = 1'b1; #1;
      n_tests++; if ({Btb_Wr, Flush} !== 2'b11) begin n_fail++; $display("FAIL stall_entry got=%b exp=11", {Btb_Wr, Flush}); end
      n_tests++; if (Btb_Wr_Target !== 32'h0000_1000) begin n_fail++; $display("FAIL stall_btb_tgt got=%h exp=00001000", Btb_Wr_Target); end
      for (int i = 0; i < 2; i++) begin
         step(); #1;
         n_tests++; if (Btb_Wr !== 1'b0) begin n_fail++; $display("FAIL stall_btb_pulse got=%0b exp=0", Btb_Wr); end
         n_tests++; if ({dbg_state, Flush} !== 3'b011) begin n_fail++; $display("FAIL stall_hold got=%b exp=011", {dbg_state, Flush}); end
         n_tests++; if (Next_PC !== 32'h0000_1000) begin n_fail++; $display("FAIL stall_next_pc got=%h exp=00001000", Next_PC); end
      end
      Stall_Detected = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1; if (Flush) flush_cycles_seen++;
         step();
      end
      n_tests++; if (flush_cycles_seen !== 2) begin n_fail++; $display("FAIL stall_flush_len got=%0d exp=2", flush_cycles_seen); end
      n_tests++; if (dbg_ctr !== 16'h5565) begin n_fail++; $display("FAIL stall_ctr got=%h exp=5565", dbg_ctr); end
      n_tests++; if (Mispredict_Cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=3", Mispredict_Cnt); end
   endtask

   task automatic test_drain_ignore();
      ex_drive(32'h1234_0004, 32'h0000_4000, 1'b1, 1'b0, 32'h0);
      step(); ex_idle();
      step();
      ex_drive(32'h1234_000C, 32'h0000_5000, 1'b1, 1'b0, 32'h0); #1;
      n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL drain_state got=%0d exp=2", dbg_state); end
      step(); ex_idle(); #1;
      n_tests++; if (Btb_Wr !== 1'b0) begin n_fail++; $display("FAIL drain_btb got=%0b exp=0", Btb_Wr); end
      n_tests++; if (dbg_ctr !== 16'h5569) begin n_fail++; $display("FAIL drain_ctr got=%h exp=5569", dbg_ctr); end
      n_tests++; if (Mispredict_Cnt !== 16'd4) begin n_fail++; $display("FAIL drain_cnt got=%0d exp=4", Mispredict_Cnt); end
      n_tests++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL drain_flush_end got=%0b exp=0", Flush); end
   endtask

   task automatic test_ctr_floor();
      for (int i = 0; i < 2; i++) begin
         ex_drive(32'h1234_0018, 32'h0, 1'b0, 1'b0, 32'h0);
         step();
      end
      ex_idle(); #1;
      n_tests++; if (dbg_ctr !== 16'h4569) begin n_fail++; $display("FAIL floor_ctr got=%h exp=4569", dbg_ctr); end
      n_tests++; if ({Flush, Btb_Wr, Mispredict_Cnt} !== {2'b00, 16'd4}) begin n_fail++; $display("FAIL floor_quiet got=%h exp=00004", {Flush, Btb_Wr, Mispredict_Cnt}); end
   endtask

   task automatic test_reset_in_drain();
      ex_drive(32'h1234_0014, 32'h0000_6000, 1'b1, 1'b0, 32'h0);
      step(); ex_idle();
      step(); #1;
      n_tests++; if ({dbg_state, Flush} !== 3'b101) begin n_fail++; $display("FAIL rst_pre_drain got=%b exp=101", {dbg_state, Flush}); end
      rst_n = 1'b0;
      step(); #1;
      n_tests++; if ({dbg_state, Flush} !== 3'b000) begin n_fail++; $display("FAIL rst_abort got=%b exp=000", {dbg_state, Flush}); end
      n_tests++; if (dbg_ctr !== 16'h5555) begin n_fail++; $display("FAIL rst_ctr got=%h exp=5555", dbg_ctr); end
      n_tests++; if (Mispredict_Cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", Mispredict_Cnt); end
      n_tests++; if ({Btb_Wr, Btb_Wr_PC, Btb_Wr_Target} !== 65'd0) begin n_fail++; $display("FAIL rst_btb got=%h exp=0", {Btb_Wr, Btb_Wr_PC, Btb_Wr_Target}); end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_mispredict_taken();
      test_saturate();
      test_stall_redirect();
      test_drain_ignore();
      test_ctr_floor();
      test_reset_in_drain();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
